// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start bit, 7 data bits LSB first, even parity, 1 stop bit.
// Delivers one character per frame with a strobe, a sticky availability flag and error strobes.
`timescale 1ns/1ps
module rx_serial_7e1 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       limpa,
  output logic [6:0] dados,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic [3:0] db_estado
);

  localparam int M    = CLK_FREQ / BAUD;
  localparam int HALF = M / 2;
  localparam int CW   = $clog2(M);
  localparam logic [CW-1:0] LAST_BIT  = CW'(M - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    START       = 4'd1,
    DADOS       = 4'd2,
    PARIDADE    = 4'd3,
    STOP        = 4'd4,
    ENTREGA     = 4'd5,
    ESPERA_ALTO = 4'd6
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [6:0]    shift_reg, shift_next;
  logic          par_err_reg, par_err_next;
  logic [6:0]    dados_reg, dados_next;
  logic          pronto_reg, pronto_next;
  logic          tem_dado_reg, tem_dado_next;
  logic          perr_reg, perr_next;
  logic          ferr_reg, ferr_next;
  logic          rx_meta_reg, rxs_reg;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rxs_reg     <= rx_meta_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= INICIAL;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      par_err_reg  <= 1'b0;
      dados_reg    <= '0;
      pronto_reg   <= 1'b0;
      tem_dado_reg <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      par_err_reg  <= par_err_next;
      dados_reg    <= dados_next;
      pronto_reg   <= pronto_next;
      tem_dado_reg <= tem_dado_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    par_err_next  = par_err_reg;
    dados_next    = dados_reg;
    pronto_next   = 1'b0;
    perr_next     = 1'b0;
    ferr_next     = 1'b0;
    tem_dado_next = limpa ? 1'b0 : tem_dado_reg;

    unique case (state_reg)
      INICIAL: begin
        if (!rxs_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == LAST_HALF) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rxs_reg ? INICIAL : DADOS;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DADOS: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next   = '0;
          shift_next = {rxs_reg, shift_reg[6:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd6) state_next = PARIDADE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PARIDADE: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next     = '0;
          par_err_next = rxs_reg ^ (^shift_reg);
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next = '0;
          if (rxs_reg) begin
            state_next = ENTREGA;
          end else begin
            ferr_next  = 1'b1;
            state_next = ESPERA_ALTO;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ENTREGA: begin
        // Set of tem_dado takes priority over a simultaneous limpa.
        dados_next    = shift_reg;
        pronto_next   = 1'b1;
        tem_dado_next = 1'b1;
        perr_next     = par_err_reg;
        state_next    = INICIAL;
      end
      ESPERA_ALTO: begin
        if (rxs_reg) state_next = INICIAL;
      end
      default: state_next = INICIAL;
    endcase
  end

  assign dados         = dados_reg;
  assign pronto        = pronto_reg;
  assign tem_dado      = tem_dado_reg;
  assign erro_paridade = perr_reg;
  assign erro_frame    = ferr_reg;
  assign db_estado     = state_reg;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Scoreboard bench for rx_serial_7e1: sender at 115000 bit/s, monitor pops expected events on strobes.
`timescale 1ns/1ps
module tb_rx_serial_7e1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RX = 1'b1;
  logic       limpa = 1'b0;
  logic [6:0] dados;
  logic       pronto, tem_dado, erro_paridade, erro_frame;
  logic [3:0] db_estado;

  rx_serial_7e1 dut (
    .clock(clock), .reset(reset), .RX(RX), .limpa(limpa),
    .dados(dados), .pronto(pronto), .tem_dado(tem_dado),
    .erro_paridade(erro_paridade), .erro_frame(erro_frame), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  localparam realtime BIT_NS = 1.0e9 / 115000.0;

  typedef struct {
    bit         kind;   // 0 = delivered character, 1 = framing error
    logic [6:0] data;
    bit         perr;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  n_pronto = 0;
  int  n_ferr = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_ev(input bit kind, input logic [6:0] data, input bit perr);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [6:0] data, input logic par, input logic stop);
    RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 7; i++) begin
      RX = data[i];
      #(BIT_NS);
    end
    RX = par;
    #(BIT_NS);
    RX = stop;
    #(BIT_NS);
  endtask

  task automatic idle(input int nbits);
    RX = 1'b1;
    #(nbits * BIT_NS);
  endtask

  // Monitor: one line per observed strobe, compared against the head of the scoreboard.
  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (erro_paridade) chk("perr_with_pronto", int'(pronto), 1);
      if (pronto || erro_frame) begin
        if (pronto) n_pronto++;
        if (erro_frame) n_ferr++;
        chk("strobe_overlap", int'(pronto & erro_frame), 0);
        chk("strobe_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev_t e;
          e = exp_q.pop_front();
          $display("event: pronto=%0b erro_frame=%0b dados=0x%02h erro_paridade=%0b", pronto, erro_frame,
                   dados, erro_paridade);
          chk("event_kind", int'(erro_frame), int'(e.kind));
          if (pronto) begin
            chk("dados", int'(dados), int'(e.data));
            chk("erro_paridade", int'(erro_paridade), int'(e.perr));
            chk("tem_dado_on_pronto", int'(tem_dado), 1);
          end
        end
      end
    end
  end

  logic [6:0] t2_data [3] = '{7'h30, 7'h31, 7'h32};
  logic       t2_par  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    repeat (5) @(negedge clock);
    chk("reset_dados", int'(dados), 0);
    chk("reset_tem_dado", int'(tem_dado), 0);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_pronto", int'(pronto), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // 1: single '0'
    push_ev(1'b0, 7'h30, 1'b0);
    send_frame(7'h30, 1'b0, 1'b1);
    idle(2);
    @(negedge clock);
    chk("t1_dados", int'(dados), 'h30);
    chk("t1_tem_dado", int'(tem_dado), 1);

    // 2: three frames with limpa after each
    for (int k = 0; k < 3; k++) begin
      push_ev(1'b0, t2_data[k], 1'b0);
      send_frame(t2_data[k], t2_par[k], 1'b1);
      idle(10);
      @(negedge clock);
      chk("t2_tem_dado_set", int'(tem_dado), 1);
      chk("t2_dados", int'(dados), int'(t2_data[k]));
      limpa = 1'b1;
      @(negedge clock);
      limpa = 1'b0;
      chk("t2_tem_dado_clr", int'(tem_dado), 0);
    end

    // 3: wrong parity on 0x31
    push_ev(1'b0, 7'h31, 1'b1);
    send_frame(7'h31, 1'b0, 1'b1);
    idle(2);
    @(negedge clock);
    chk("t3_dados", int'(dados), 'h31);

    // 4: stop bit low followed by a break, then a clean 0x33
    push_ev(1'b1, 7'h00, 1'b0);
    send_frame(7'h32, 1'b1, 1'b0);
    RX = 1'b0;
    #(20 * BIT_NS);
    @(negedge clock);
    chk("t4_espera_alto", int'(db_estado), 6);
    idle(3);
    @(negedge clock);
    chk("t4_dados_kept", int'(dados), 'h31);
    chk("t4_estado_idle", int'(db_estado), 0);
    push_ev(1'b0, 7'h33, 1'b0);
    send_frame(7'h33, 1'b0, 1'b1);
    idle(2);
    @(negedge clock);
    chk("t4_dados_33", int'(dados), 'h33);

    // 5: glitch shorter than half a bit
    @(negedge clock);
    RX = 1'b0;
    repeat (100) @(negedge clock);
    chk("t5_in_start", int'(db_estado), 1);
    RX = 1'b1;
    repeat (200) @(negedge clock);
    chk("t5_back_idle", int'(db_estado), 0);

    // 6: reset during the data bits of 0x55
    RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      RX = i[0] ? 1'b0 : 1'b1;
      #(BIT_NS);
    end
    RX = 1'b1;
    #(BIT_NS / 2);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("t6_dados_rst", int'(dados), 0);
    chk("t6_tem_dado_rst", int'(tem_dado), 0);
    idle(12);
    @(negedge clock);
    chk("t6_estado", int'(db_estado), 0);
    chk("t6_tem_dado_idle", int'(tem_dado), 0);
    push_ev(1'b0, 7'h41, 1'b0);
    send_frame(7'h41, 1'b0, 1'b1);
    idle(2);
    @(negedge clock);
    chk("t6_dados_41", int'(dados), 'h41);

    chk("queue_left", exp_q.size(), 0);
    chk("pronto_count", n_pronto, 7);
    chk("erro_frame_count", n_ferr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
